// File: rtl/sparc_exu_byp_eccchk_if.sv
// rtl/sparc_exu_byp_eccchk_if.sv - bus bundle for the (72,64) SEC-DED checker
interface sparc_exu_byp_eccchk_if;
  logic        vld_i;
  logic [63:0] din_i;
  logic [7:0]  cin_i;
  logic        err_clr_i;
  logic        vld_o;
  logic [63:0] dout_o;
  logic [7:0]  syn_o;
  logic        ce_o;
  logic        ue_o;
  logic [7:0]  ce_cnt_o;
  logic [3:0]  ue_cnt_o;
  logic        log_vld_o;
  logic [7:0]  log_syn_o;
  logic        log_ue_o;

  modport master (
    output vld_i, din_i, cin_i, err_clr_i,
    input  vld_o, dout_o, syn_o, ce_o, ue_o, ce_cnt_o, ue_cnt_o,
           log_vld_o, log_syn_o, log_ue_o
  );

  modport slave (
    input  vld_i, din_i, cin_i, err_clr_i,
    output vld_o, dout_o, syn_o, ce_o, ue_o, ce_cnt_o, ue_cnt_o,
           log_vld_o, log_syn_o, log_ue_o
  );
endinterface

// File: rtl/sparc_exu_byp_eccchk.sv
// rtl/sparc_exu_byp_eccchk.sv - two-stage (72,64) SEC-DED check/correct with error counters and log
module sparc_exu_byp_eccchk (
  input logic                   clk,
  input logic                   rst,
  sparc_exu_byp_eccchk_if.slave bus
);

  // Hamming position of each data bit: 3..71 skipping powers of two.
  function automatic logic [63:0][6:0] build_pos();
    logic [63:0][6:0] t;
    int               n;
    t = '0;
    n = 0;
    for (int q = 3; q < 72; q++) begin
      if ((q & (q - 1)) != 0) begin
        t[n] = 7'(q);
        n++;
      end
    end
    return t;
  endfunction

  localparam logic [63:0][6:0] POS = build_pos();

  function automatic logic [6:0][63:0] build_masks();
    logic [6:0][63:0] m;
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 64; j++) begin
        m[i][j] = POS[j][i];
      end
    end
    return m;
  endfunction

  localparam logic [6:0][63:0] CHK_MASK = build_masks();

  logic        vld1_q;
  logic [63:0] data1_q;
  logic [7:0]  syn1_q;
  logic [7:0]  syn1_d;

  logic        vld2_q;
  logic [63:0] dout_q, dout_d;
  logic [7:0]  syn2_q;
  logic        ce_q, ce_d;
  logic        ue_q, ue_d;
  logic [63:0] flip;
  logic [6:0]  s;
  logic        par;

  logic [7:0]  ce_cnt_q, ce_cnt_d, ce_base;
  logic [3:0]  ue_cnt_q, ue_cnt_d, ue_base;
  logic        log_vld_q, log_vld_d, log_vld_base;
  logic [7:0]  log_syn_q, log_syn_d;
  logic        log_ue_q, log_ue_d;

  // Each check term is a sum of byte-wide (8-input) partial parities.
  always_comb begin
    syn1_d = '0;
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 8; b++) begin
        syn1_d[i] = syn1_d[i] ^ (^(bus.din_i[b*8 +: 8] & CHK_MASK[i][b*8 +: 8]));
      end
      syn1_d[i] = syn1_d[i] ^ bus.cin_i[i];
    end
    for (int b = 0; b < 8; b++) begin
      syn1_d[7] = syn1_d[7] ^ (^bus.din_i[b*8 +: 8]);
    end
    syn1_d[7] = syn1_d[7] ^ (^bus.cin_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld1_q  <= 1'b0;
      data1_q <= '0;
      syn1_q  <= '0;
    end else begin
      vld1_q  <= bus.vld_i;
      data1_q <= bus.din_i;
      syn1_q  <= syn1_d;
    end
  end

  // Odd overall parity with a valid position is a single error; positions
  // 0 and powers of two are check bits, so no data bit matches and none flips.
  always_comb begin
    s    = syn1_q[6:0];
    par  = syn1_q[7];
    flip = '0;
    for (int j = 0; j < 64; j++) begin
      flip[j] = par & (POS[j] == s);
    end
    ue_d   = vld1_q & (par ? (s > 7'd71) : (s != 7'd0));
    ce_d   = vld1_q & par & (s <= 7'd71);
    dout_d = data1_q ^ flip;
  end

  // A clear in the same cycle as an error is applied first, then the error counts.
  always_comb begin
    ce_base      = bus.err_clr_i ? 8'd0 : ce_cnt_q;
    ue_base      = bus.err_clr_i ? 4'd0 : ue_cnt_q;
    log_vld_base = bus.err_clr_i ? 1'b0 : log_vld_q;
    ce_cnt_d     = ce_base + {7'd0, (ce_d && (ce_base != 8'hFF))};
    ue_cnt_d     = ue_base + {3'd0, (ue_d && (ue_base != 4'hF))};
    log_vld_d    = log_vld_base;
    log_syn_d    = bus.err_clr_i ? 8'd0 : log_syn_q;
    log_ue_d     = bus.err_clr_i ? 1'b0 : log_ue_q;
    if (!log_vld_base && (ce_d || ue_d)) begin
      log_vld_d = 1'b1;
      log_syn_d = syn1_q;
      log_ue_d  = ue_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld2_q    <= 1'b0;
      dout_q    <= '0;
      syn2_q    <= '0;
      ce_q      <= 1'b0;
      ue_q      <= 1'b0;
      ce_cnt_q  <= '0;
      ue_cnt_q  <= '0;
      log_vld_q <= 1'b0;
      log_syn_q <= '0;
      log_ue_q  <= 1'b0;
    end else begin
      vld2_q    <= vld1_q;
      dout_q    <= dout_d;
      syn2_q    <= syn1_q;
      ce_q      <= ce_d;
      ue_q      <= ue_d;
      ce_cnt_q  <= ce_cnt_d;
      ue_cnt_q  <= ue_cnt_d;
      log_vld_q <= log_vld_d;
      log_syn_q <= log_syn_d;
      log_ue_q  <= log_ue_d;
    end
  end

  assign bus.vld_o     = vld2_q;
  assign bus.dout_o    = dout_q;
  assign bus.syn_o     = syn2_q;
  assign bus.ce_o      = ce_q;
  assign bus.ue_o      = ue_q;
  assign bus.ce_cnt_o  = ce_cnt_q;
  assign bus.ue_cnt_o  = ue_cnt_q;
  assign bus.log_vld_o = log_vld_q;
  assign bus.log_syn_o = log_syn_q;
  assign bus.log_ue_o  = log_ue_q;

endmodule
